// File: rtl/btn_req_debounce_pkg.sv
// Shared constants and helpers for the four-channel button request front end.
package btn_req_debounce_pkg;

    localparam int N_BTN                   = 4;
    localparam int IDX_W                   = $clog2(N_BTN);
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    // One-hot mask selecting the request named by an encoder index.
    function automatic logic [N_BTN-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
        idx_to_mask      = '0;
        idx_to_mask[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/btn_req_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, stable level and
// a registered pulse on each debounced press.
module debounce_ch
    import btn_req_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] count;
    logic             differ;
    logic             flip;

    assign differ = (sync2 != stable);
    assign flip   = differ && (count == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Any cycle where the synchronised input agrees with stable restarts the count,
    // so only an uninterrupted run of DEBOUNCE_CYCLES differing cycles commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
        end else begin
            rise <= flip && sync2;
            if (!differ) begin
                count <= '0;
            end else if (flip) begin
                stable <= sync2;
                count  <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/btn_req_debounce.sv
// Four debounced buttons feeding sticky pending requests for a priority encoder;
// a served request is cleared by ack with the encoder's index.
module btn_req_debounce
    import btn_req_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    output logic [N_BTN-1:0] stable,
    output logic [N_BTN-1:0] rise,
    output logic [N_BTN-1:0] pending,
    output logic             any_pending
);

    logic [N_BTN-1:0] ack_mask;
    logic [N_BTN-1:0] pending_next;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (btn_raw[i]),
            .stable(stable[i]),
            .rise  (rise[i])
        );
    end

    // ack is a single-cycle strobe with no back-pressure: it is consumed on the
    // edge that samples it. A press landing on the same edge as its own ack wins,
    // and an ack naming an idle request has nothing to clear.
    always_comb begin
        ack_mask     = ack ? idx_to_mask(ack_idx) : '0;
        pending_next = (pending & ~ack_mask) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            any_pending <= 1'b0;
        end else begin
            pending     <= pending_next;
            any_pending <= |pending_next;
        end
    end

endmodule

// File: tb/tb_btn_req_debounce.sv
// Bench for btn_req_debounce with DEBOUNCE_CYCLES=4: directed scenarios plus a
// randomized run, all checked against a window-based behavioural model.
module tb_btn_req_debounce;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_raw;
    logic       ack;
    logic [1:0] ack_idx;
    logic [3:0] stable;
    logic [3:0] rise;
    logic [3:0] pending;
    logic       any_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_req_debounce #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .ack        (ack),
        .ack_idx    (ack_idx),
        .stable     (stable),
        .rise       (rise),
        .pending    (pending),
        .any_pending(any_pending)
    );

    // Reference: a channel's debounced level flips once the raw samples that
    // reached the synchroniser output over the last D edges all disagree with it.
    logic [3:0] m_stable, m_rise, m_pending;
    logic       m_any;
    logic [3:0] samp_q[$];
    logic [3:0] n_stable, n_pend;
    int         run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_stable  = '0;
            m_rise    = '0;
            m_pending = '0;
            m_any     = 1'b0;
            samp_q.delete();
        end else begin
            n_stable = m_stable;
            for (int i = 0; i < 4; i++) begin
                if (samp_q.size() >= D + 1) begin
                    run = 0;
                    for (int j = 0; j < D; j++)
                        if (samp_q[samp_q.size() - 2 - j][i] != m_stable[i]) run++;
                    if (run == D) n_stable[i] = ~m_stable[i];
                end
            end
            n_pend = m_pending;
            if (ack) n_pend[ack_idx] = 1'b0;
            n_pend    = n_pend | m_rise;
            m_rise    = n_stable & ~m_stable;
            m_stable  = n_stable;
            m_pending = n_pend;
            m_any     = |n_pend;
            samp_q.push_back(btn_raw);
            if (samp_q.size() > D + 1) void'(samp_q.pop_front());
        end
    end

    task automatic test_reset();
        rst_n   = 1'b0;
        btn_raw = 4'b0000;
        ack     = 1'b0;
        ack_idx = 2'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({stable, rise, pending, any_pending} !== 13'd0) begin
            errors++;
            $display("FAIL reset_state: got %b want 0", {stable, rise, pending, any_pending});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        btn_raw = 4'b0100;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clk);
            checks++;
            if ({stable, rise, pending, any_pending} !== {m_stable, m_rise, m_pending, m_any}) begin
                errors++;
                $display("FAIL clean_model t=%0d: got %b want %b", t,
                         {stable, rise, pending, any_pending}, {m_stable, m_rise, m_pending, m_any});
            end
            if (t == 5) begin
                checks++;
                if (stable !== 4'b0000) begin
                    errors++;
                    $display("FAIL clean_early: stable=%b want 0000", stable);
                end
            end
            if (t == 6) begin
                checks++;
                if (stable !== 4'b0100 || rise !== 4'b0100) begin
                    errors++;
                    $display("FAIL clean_rise: stable=%b rise=%b want 0100/0100", stable, rise);
                end
            end
            if (t == 7) begin
                checks++;
                if (rise !== 4'b0000 || pending !== 4'b0100 || any_pending !== 1'b1) begin
                    errors++;
                    $display("FAIL clean_pending: rise=%b pending=%b any=%b want 0000/0100/1",
                             rise, pending, any_pending);
                end
            end
        end
        btn_raw = 4'b0000;
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (rise !== 4'b0000 || pending !== 4'b0100) begin
                errors++;
                $display("FAIL release_no_pulse: rise=%b pending=%b want 0000/0100", rise, pending);
            end
        end
        ack = 1'b1; ack_idx = 2'd2;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (pending !== 4'b0000 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL clean_ack: pending=%b any=%b want 0000/0", pending, any_pending);
        end
    endtask

    task automatic test_bounce();
        logic [0:0] pat[14] = '{1,1,1,0,0,1,1,1,0,0,0,0,0,0};
        for (int t = 0; t < 14; t++) begin
            btn_raw = {3'b000, pat[t]};
            @(negedge clk);
            checks++;
            if ({stable, rise, pending} !== 12'd0) begin
                errors++;
                $display("FAIL bounce t=%0d: stable=%b rise=%b pending=%b want all 0",
                         t, stable, rise, pending);
            end
        end
    endtask

    task automatic test_multi_ack();
        btn_raw = 4'b1010;
        repeat (7) @(negedge clk);
        checks++;
        if (pending !== 4'b1010 || pending !== m_pending) begin
            errors++;
            $display("FAIL multi_set: pending=%b want 1010", pending);
        end
        ack = 1'b1; ack_idx = 2'd3;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (pending !== 4'b0010 || any_pending !== 1'b1) begin
            errors++;
            $display("FAIL multi_ack3: pending=%b any=%b want 0010/1", pending, any_pending);
        end
        ack = 1'b1; ack_idx = 2'd1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (pending !== 4'b0000 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL multi_ack1: pending=%b any=%b want 0000/0", pending, any_pending);
        end
        btn_raw = 4'b0000;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_set_clear();
        btn_raw = 4'b0010;
        repeat (7) @(negedge clk);
        btn_raw = 4'b0000;
        repeat (7) @(negedge clk);
        checks++;
        if (stable !== 4'b0000 || pending !== 4'b0010) begin
            errors++;
            $display("FAIL setclr_prep: stable=%b pending=%b want 0000/0010", stable, pending);
        end
        btn_raw = 4'b0010;
        repeat (6) @(negedge clk);
        checks++;
        if (rise !== 4'b0010) begin
            errors++;
            $display("FAIL setclr_rise: rise=%b want 0010", rise);
        end
        ack = 1'b1; ack_idx = 2'd1;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (pending !== 4'b0010 || m_pending !== 4'b0010) begin
            errors++;
            $display("FAIL set_wins: pending=%b want 0010", pending);
        end
        ack = 1'b1; ack_idx = 2'd1;
        @(negedge clk);
        ack = 1'b0;
        btn_raw = 4'b0000;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_stale_ack();
        btn_raw = 4'b0001;
        repeat (7) @(negedge clk);
        btn_raw = 4'b0000;
        repeat (7) @(negedge clk);
        ack = 1'b1; ack_idx = 2'd2;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (pending !== 4'b0001 || any_pending !== 1'b1) begin
            errors++;
            $display("FAIL stale_ack: pending=%b any=%b want 0001/1", pending, any_pending);
        end
        ack = 1'b1; ack_idx = 2'd0;
        @(negedge clk);
        checks++;
        if (pending !== 4'b0000 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL stale_clear: pending=%b any=%b want 0000/0", pending, any_pending);
        end
        ack_idx = 2'd3;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if (pending !== 4'b0000 || any_pending !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: pending=%b any=%b want 0000/0", pending, any_pending);
        end
    endtask

    task automatic test_reset_mid();
        btn_raw = 4'b1000;
        repeat (7) @(negedge clk);
        btn_raw = 4'b1100;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({stable, rise, pending, any_pending} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b want 0", {stable, rise, pending, any_pending});
        end
        btn_raw = 4'b1000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            checks++;
            if ({stable, rise, pending, any_pending} !== {m_stable, m_rise, m_pending, m_any}) begin
                errors++;
                $display("FAIL reset_mid_model t=%0d: got %b want %b", t,
                         {stable, rise, pending, any_pending}, {m_stable, m_rise, m_pending, m_any});
            end
            if (t == 5 || t == 6) begin
                checks++;
                if (rise !== (t == 6 ? 4'b1000 : 4'b0000)) begin
                    errors++;
                    $display("FAIL reset_mid_rise t=%0d: rise=%b", t, rise);
                end
            end
        end
        checks++;
        if (pending !== 4'b1000 || any_pending !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pending: pending=%b any=%b want 1000/1", pending, any_pending);
        end
        btn_raw = 4'b0000;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        int hold[4];
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4)
                                                          : $urandom_range(5, 14);
                end else begin
                    hold[i]--;
                end
            end
            ack     = ($urandom_range(0, 3) == 0);
            ack_idx = 2'($urandom_range(0, 3));
            @(negedge clk);
            checks++;
            if ({stable, rise, pending, any_pending} !== {m_stable, m_rise, m_pending, m_any}) begin
                errors++;
                $display("FAIL random t=%0d: got %b want %b", t,
                         {stable, rise, pending, any_pending}, {m_stable, m_rise, m_pending, m_any});
            end
        end
        ack = 1'b0;
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_clean_press();
        test_bounce();
        test_multi_ack();
        test_set_clear();
        test_stale_ack();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_req_debounce.md
# btn_req_debounce

Four-channel push-button front end that sits directly upstream of the 4-to-2 priority encoder. It synchronises and debounces four raw button inputs, generates one-cycle press pulses, and holds each press as a sticky pending request. The `pending` vector drives the encoder's request input. The encoder's output index plus an acknowledge strobe clear the served request, so presses are never lost while a higher-priority request is being handled.

## Interface

- `DEBOUNCE_CYCLES`, default 1000000 (10 ms at 100 MHz): consecutive cycles a synchronised input must differ from the debounced state before that state changes; legal range 2 to 2^24.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width; derived, never overridden.

Ports:
- `clk`  in  1  system clock; every flop is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `btn_raw`  in  4  raw, asynchronous, bouncing button levels; bit 3 is highest priority downstream.
- `ack`  in  1  one-cycle strobe meaning the request named by `ack_idx` has been served.
- `ack_idx`  in  2  index of the served request; taken from the encoder `Y` output.
- `stable`  out  4  debounced button levels.
- `rise`  out  4  one-cycle pulse on each debounced 0→1 transition.
- `pending`  out  4  sticky requests; connects to the encoder `I` input.
- `any_pending`  out  1  OR-reduction of `pending`, registered.

## Operation

- **Per-channel path:** 2-flop synchroniser → debounce counter → `stable` flop.
- **Counter rule, each cycle per channel:**
  - If `sync == stable`, the counter clears to 0.
  - Otherwise, if `counter == DEBOUNCE_CYCLES-1`, `stable` takes the value of `sync` and the counter clears.
  - Otherwise, the counter increments.
  - The counter never wraps; by construction it never exceeds `DEBOUNCE_CYCLES-1`.
- **Bounce rejection:** any glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles resets the count and never reaches `stable`.
- **Press pulse:** `rise[i]` is registered. It is high for exactly the one cycle in which `stable[i]` first reads 1. Release (1→0) produces no pulse.
- **Pending, per bit, next-state priority:**
  1. `rise[i]` sets the bit.
  2. Otherwise, `ack && ack_idx==i` clears it.
  3. Otherwise, it holds.
  
  Set wins over a simultaneous clear, so a new press arriving while the same bit is being acknowledged stays pending.
- **Stale ack:** an `ack` naming a bit that is already 0 has no effect.
- **`ack` without requests:** an `ack` while `any_pending==0` is ignored.
- **Independence:** multiple channels may rise in the same cycle; all of them set.
- **`any_pending`:** registered from the next-state value of `pending`, so it is cycle-aligned with `pending`.

## Timing

- **Reset:** while `rst_n` is low, all outputs are 0: `stable=0`, `rise=0`, `pending=0`, `any_pending=0`. Synchroniser flops and counters are also 0. Assertion takes effect immediately, with no clock required.
- **Reset mid-operation:** asserting reset during a count or while requests are pending discards everything. After release, a button still held re-debounces from 0 and yields a fresh `rise`.
- **Press latency:** `btn_raw[i]` goes high and stays high from just before edge k.
  - Synchroniser output is 1 after edge k+1.
  - `stable[i]` and `rise[i]` are 1 after edge k+1+`DEBOUNCE_CYCLES`.
  - `pending[i]` and `any_pending` are 1 one edge later.
- **Release latency:** the same count applies, i.e. `stable[i]` is 0 after edge k+1+`DEBOUNCE_CYCLES`, with no pulse.
- **Ack latency:** `ack` sampled at edge m clears `pending[ack_idx]` after edge m. The encoder sees the new request set in the following cycle.
- **Input domains:** `ack` and `ack_idx` are synchronous to `clk`. `btn_raw` is fully asynchronous.

## Structure

- **Shared package:** `N_BTN = 4` and the default `DEBOUNCE_CYCLES` constant. The top-level width of `btn_raw`, `stable`, `rise` and `pending` is `N_BTN`.
- **Sub-module `debounce_ch`:** one instance per channel, containing the synchroniser, counter, `stable` flop and registered rise pulse. Ports: `clk`, `rst_n`, `din`, `stable`, `rise`; parameter `DEBOUNCE_CYCLES`.
- **Top level:** instantiates four `debounce_ch` and holds the `pending` / `any_pending` logic.

## Test plan

Run with `DEBOUNCE_CYCLES=4`.

- **Clean press:** `btn_raw=4'b0100` held 10 cycles.
  - `stable[2]` rises 5 edges after the input change.
  - `rise=4'b0100` for exactly 1 cycle.
  - `pending=4'b0100` and `any_pending=1` one edge later.
- **Bounce:** `btn_raw[0]` toggles 1,0,1,0 with 3-cycle high pulses, then stays 0.
  - `stable`, `rise` and `pending` remain 0 throughout.
- **Multiple requests and ack sequence:** press bits 3 and 1 together.
  - `pending=4'b1010`.
  - `ack`, `ack_idx=3` → `pending=4'b0010`.
  - `ack`, `ack_idx=1` → `pending=0`, `any_pending=0`.
- **Simultaneous set and clear:** `pending[1]=1`; release and re-press bit 1 so that `rise[1]` coincides with `ack`, `ack_idx=1`.
  - `pending[1]` stays 1.
- **Stale ack:** `ack`, `ack_idx=2` with `pending=4'b0001`.
  - `pending` is unchanged at `4'b0001`.
- **Reset mid-operation:** assert `rst_n=0` mid-count with `pending=4'b1000` and the button still held.
  - All outputs are 0 immediately.
  - After release, the held button produces `rise[3]` 5 edges later and `pending=4'b1000` again.
